// File: rtl/led_sequencer_pwm.sv
// N-slot LED sequencer with per-slot, per-channel PWM levels, repeat or one-shot runs.
// led/slot_idx/busy lag the state/slot registers by one clk; no backpressure, outputs free-run.
module led_sequencer_pwm #(
  parameter int NUM_SLOTS = 8,
  parameter int CHANNELS  = 3,
  parameter int DUR_W     = 12,
  parameter int PWM_W     = 8,
  parameter int TICK_DIV  = 12000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                one_shot,
  input  logic                                start,
  input  logic [NUM_SLOTS*DUR_W-1:0]          duration,
  input  logic [NUM_SLOTS*CHANNELS*PWM_W-1:0] level,
  output logic [CHANNELS-1:0]                 led,
  output logic [$clog2(NUM_SLOTS)-1:0]        slot_idx,
  output logic                                busy,
  output logic                                done
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PWM_W-1:0]  PWM_LAST  = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [DUR_W-1:0]  CNT_ONE   = DUR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic [DUR_W-1:0]    cnt, cnt_nxt;
  logic [DUR_W-1:0]    dur_first, dur_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic                tick, launch;
  logic [CHANNELS-1:0] led_nxt;

  assign dur_first = duration[DUR_W-1:0];
  assign tick      = (state == RUN) && (tick_cnt == TICK_LAST);
  assign launch    = enable && (dur_first != '0) && (!one_shot || start);

  // Duration of the following slot; reads as 0 past the last slot, which ends the sequence.
  always_comb begin
    dur_next = '0;
    for (int k = 1; k < NUM_SLOTS; k++)
      if (k == int'(slot) + 1) dur_next = duration[k*DUR_W +: DUR_W];
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (launch) begin
          state_nxt = RUN;
          slot_nxt  = '0;
          cnt_nxt   = dur_first;
        end
      end
      RUN: begin
        if (tick) begin
          if (cnt != CNT_ONE) begin
            cnt_nxt = cnt - CNT_ONE;
          end else if (dur_next != '0) begin
            slot_nxt = slot + 1'b1;
            cnt_nxt  = dur_next;
          end else if (one_shot) begin
            state_nxt = DONE;
          end else if (dur_first != '0) begin
            slot_nxt = '0;
            cnt_nxt  = dur_first;
          end else begin
            state_nxt = IDLE;
            slot_nxt  = '0;
            cnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int c = 0; c < CHANNELS; c++)
      led_nxt[c] = (state == RUN) &&
                   (pwm_cnt < level[(int'(slot)*CHANNELS + c)*PWM_W +: PWM_W]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot     <= '0;
      cnt      <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      led      <= '0;
      slot_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      cnt      <= cnt_nxt;
      // Held at 0 outside RUN so every entry into RUN starts a full tick.
      tick_cnt <= (state == RUN && state_nxt == RUN && !tick) ? tick_cnt + 1'b1 : '0;
      pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      led      <= led_nxt;
      slot_idx <= slot;
      busy     <= (state == RUN);
      done     <= (state == RUN) && (state_nxt == DONE);
    end
  end
endmodule
